// File: rtl/text_buffer_writer_pkg.sv
// Shared constants, state encoding and a character-class helper for the
// text buffer write side.
package text_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int FIRST_ROW = 1;
  localparam int AW        = 12;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;

  localparam int KB_UP    = 8;
  localparam int KB_DOWN  = 7;
  localparam int KB_LEFT  = 6;
  localparam int KB_RIGHT = 5;

  typedef enum logic [2:0] {
    CLEAR_ALL,
    IDLE,
    EXEC,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_CLR
  } state_t;

  // Printable ASCII range that is written straight into the buffer.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_buffer_writer_cursor_next.sv
// Combinational event decoder: from the current cursor (address plus
// row/col counters) and a registered key event, produce the next cursor,
// the write (if any) and whether the event needs a scroll.
module text_cursor_next #(
  parameter int COLS      = text_pkg::COLS,
  parameter int ROWS      = text_pkg::ROWS,
  parameter int FIRST_ROW = text_pkg::FIRST_ROW,
  parameter int AW        = text_pkg::AW,
  parameter int RW        = $clog2(ROWS),
  parameter int CW        = $clog2(COLS)
) (
  input  logic [AW-1:0] cursor,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [7:0]    ascii,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  output logic [AW-1:0] next_cursor,
  output logic [RW-1:0] next_row,
  output logic [CW-1:0] next_col,
  output logic          write,
  output logic [AW-1:0] write_addr,
  output logic [7:0]    write_data,
  output logic          scroll_req
);
  import text_pkg::*;

  localparam logic [AW-1:0] REGION_START = AW'(FIRST_ROW * COLS);
  localparam logic [AW-1:0] BUF_END      = AW'(ROWS * COLS - 1);
  localparam logic [AW-1:0] COLS_A       = AW'(COLS);
  localparam logic [RW-1:0] FIRST_ROW_R  = RW'(FIRST_ROW);
  localparam logic [RW-1:0] LAST_ROW_R   = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL     = CW'(COLS - 1);

  logic [RW-1:0] left_row, right_row;
  logic [CW-1:0] left_col, right_col;

  // One-step moves including the row wrap at either end of a line.
  assign left_row  = (col == '0) ? row - 1'b1 : row;
  assign left_col  = (col == '0) ? LAST_COL : col - 1'b1;
  assign right_row = (col == LAST_COL) ? row + 1'b1 : row;
  assign right_col = (col == LAST_COL) ? '0 : col + 1'b1;

  // Decode the event; arrows win over ascii, priority up>down>left>right.
  always_comb begin
    next_cursor = cursor;
    next_row    = row;
    next_col    = col;
    write       = 1'b0;
    write_addr  = cursor;
    write_data  = ascii;
    scroll_req  = 1'b0;
    if (up) begin
      if (row > FIRST_ROW_R) begin
        next_cursor = cursor - COLS_A;
        next_row    = row - 1'b1;
      end
    end else if (down) begin
      if (row < LAST_ROW_R) begin
        next_cursor = cursor + COLS_A;
        next_row    = row + 1'b1;
      end
    end else if (left) begin
      if (cursor > REGION_START) begin
        next_cursor = cursor - 1'b1;
        next_row    = left_row;
        next_col    = left_col;
      end
    end else if (right) begin
      if (cursor < BUF_END) begin
        next_cursor = cursor + 1'b1;
        next_row    = right_row;
        next_col    = right_col;
      end
    end else if (is_printable(ascii)) begin
      write = 1'b1;
      // Typing past the last cell scrolls; the cursor is repositioned
      // once the scroll finishes.
      if (cursor == BUF_END) begin
        scroll_req = 1'b1;
      end else begin
        next_cursor = cursor + 1'b1;
        next_row    = right_row;
        next_col    = right_col;
      end
    end else if (ascii == CH_CR) begin
      if (row < LAST_ROW_R) begin
        next_cursor = cursor - AW'(col) + COLS_A;
        next_row    = row + 1'b1;
        next_col    = '0;
      end else begin
        scroll_req = 1'b1;
      end
    end else if (ascii == CH_BS) begin
      if (cursor > REGION_START) begin
        next_cursor = cursor - 1'b1;
        next_row    = left_row;
        next_col    = left_col;
        write       = 1'b1;
        write_addr  = cursor - 1'b1;
        write_data  = CH_SPACE;
      end
    end
  end

endmodule

// File: rtl/text_buffer_writer.sv
// Write side of the character text buffer: clears the editable region
// after reset, applies keyboard events to the cursor and buffer, and
// scrolls the editable region up by one row through the read port.
module text_buffer_writer #(
  parameter int COLS      = text_pkg::COLS,
  parameter int ROWS      = text_pkg::ROWS,
  parameter int FIRST_ROW = text_pkg::FIRST_ROW,
  parameter int AW        = text_pkg::AW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [7:0]    ascii_in,
  input  logic [15:0]   kbsig,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [AW-1:0] cursor
);
  import text_pkg::*;

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [AW-1:0] REGION_START   = AW'(FIRST_ROW * COLS);
  localparam logic [AW-1:0] LAST_ROW_START = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] SCROLL_END     = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] BUF_END        = AW'(ROWS * COLS - 1);
  localparam logic [AW-1:0] COLS_A         = AW'(COLS);
  localparam logic [RW-1:0] FIRST_ROW_R    = RW'(FIRST_ROW);
  localparam logic [RW-1:0] LAST_ROW_R     = RW'(ROWS - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] cursor_reg, cursor_next;
  logic [RW-1:0] row_reg, row_next;
  logic [CW-1:0] col_reg, col_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [7:0]    ev_ascii_reg;
  logic [3:0]    ev_kb_reg;
  logic          accept;

  logic [AW-1:0] cn_cursor, cn_waddr;
  logic [RW-1:0] cn_row;
  logic [CW-1:0] cn_col;
  logic [7:0]    cn_wdata;
  logic          cn_write, cn_scroll;

  logic          wr_en_c, ready_c;
  logic [AW-1:0] wr_addr_c, rd_addr_c;
  logic [7:0]    wr_data_c;

  logic          unused_kb_bits;
  assign unused_kb_bits = &{1'b0, kbsig[15:9], kbsig[4:0]};

  assign accept = in_valid && (state_reg == IDLE);

  text_cursor_next #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .FIRST_ROW (FIRST_ROW),
    .AW        (AW),
    .RW        (RW),
    .CW        (CW)
  ) u_cursor_next (
    .cursor      (cursor_reg),
    .row         (row_reg),
    .col         (col_reg),
    .ascii       (ev_ascii_reg),
    .up          (ev_kb_reg[3]),
    .down        (ev_kb_reg[2]),
    .left        (ev_kb_reg[1]),
    .right       (ev_kb_reg[0]),
    .next_cursor (cn_cursor),
    .next_row    (cn_row),
    .next_col    (cn_col),
    .write       (cn_write),
    .write_addr  (cn_waddr),
    .write_data  (cn_wdata),
    .scroll_req  (cn_scroll)
  );

  // State, cursor, address counter and event capture registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_reg    <= CLEAR_ALL;
      cursor_reg   <= REGION_START;
      row_reg      <= FIRST_ROW_R;
      col_reg      <= '0;
      addr_reg     <= REGION_START;
      ev_ascii_reg <= '0;
      ev_kb_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cursor_reg <= cursor_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      addr_reg   <= addr_next;
      if (accept) begin
        ev_ascii_reg <= ascii_in;
        ev_kb_reg    <= {kbsig[KB_UP], kbsig[KB_DOWN], kbsig[KB_LEFT], kbsig[KB_RIGHT]};
      end
    end
  end

  // Next-state and port decode for clear, event execution and scroll.
  always_comb begin
    state_next  = state_reg;
    cursor_next = cursor_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    addr_next   = addr_reg;
    wr_en_c     = 1'b0;
    wr_addr_c   = addr_reg;
    wr_data_c   = CH_SPACE;
    rd_addr_c   = '0;
    ready_c     = 1'b0;
    case (state_reg)
      CLEAR_ALL: begin
        wr_en_c = 1'b1;
        if (addr_reg == BUF_END) begin
          addr_next  = REGION_START;
          state_next = IDLE;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      IDLE: begin
        ready_c = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: begin
        wr_en_c   = cn_write;
        wr_addr_c = cn_waddr;
        wr_data_c = cn_wdata;
        if (cn_scroll) begin
          addr_next  = REGION_START;
          state_next = SCROLL_RD;
        end else begin
          cursor_next = cn_cursor;
          row_next    = cn_row;
          col_next    = cn_col;
          state_next  = IDLE;
        end
      end
      SCROLL_RD: begin
        rd_addr_c  = addr_reg + COLS_A;
        state_next = SCROLL_WR;
      end
      SCROLL_WR: begin
        wr_en_c   = 1'b1;
        wr_data_c = rd_data;
        if (addr_reg == SCROLL_END) begin
          addr_next  = LAST_ROW_START;
          state_next = SCROLL_CLR;
        end else begin
          addr_next  = addr_reg + 1'b1;
          state_next = SCROLL_RD;
        end
      end
      SCROLL_CLR: begin
        wr_en_c = 1'b1;
        if (addr_reg == BUF_END) begin
          cursor_next = LAST_ROW_START;
          row_next    = LAST_ROW_R;
          col_next    = '0;
          addr_next   = REGION_START;
          state_next  = IDLE;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      default: state_next = CLEAR_ALL;
    endcase
  end

  // Reset gates the strobes so nothing is written or accepted in the
  // cycle where clrn is sampled low, even mid-operation.
  assign wr_en    = wr_en_c & clrn;
  assign in_ready = ready_c & clrn;
  assign wr_addr  = wr_addr_c;
  assign wr_data  = wr_data_c;
  assign rd_addr  = rd_addr_c;
  assign cursor   = cursor_reg;

endmodule
